// File: rtl/tx_scram_seq.sv
// tx_scram_seq: transmit-side sequencer for the 64b/66b parallel scrambler.
// Seeds the scrambler after reset, feeds it one block per cycle (MAC data,
// idle fill, LPI or error blocks), delays the sync header by the scrambler's
// one-cycle latency and runs the EEE LPI / timed-wake sequence.
//
// Optional feature: define TX_SCRAM_ERRCNT_EN to build the saturating
// illegal-header counter on err_count; otherwise err_count is tied to 0.
//
// Ports:
//   CLK, rst             clock, synchronous active-high reset
//   s_valid/s_ready      MAC block handshake (s_ready combinational from state)
//   s_data, s_hdr        MAC block payload and sync header
//   lpi_req              level request for low-power idle
//   scr_data             block to scrambler (combinational mux)
//   scr_enable, scr_rst  scrambler enable / LFSR reset (combinational from state)
//   scr_dout             scrambler output
//   m_valid, m_data      output block valid (registered), scrambled block
//   m_hdr, hdr_err       registered sync header / substitution pulse
//   state                current FSM state (00 SEED, 01 ACTIVE, 10 LPI, 11 WAKE)
//   err_count            illegal-header counter
module tx_scram_seq #(
    parameter int unsigned SEED_CYCLES = 4,
    parameter int unsigned WAKE_CYCLES = 16,
    parameter logic [63:0] IDLE_BLOCK  = 64'h0000_0000_0000_001E,
    parameter logic [63:0] LPI_BLOCK   = 64'h0C18_3060_C183_061E,
    parameter logic [63:0] ERR_BLOCK   = 64'h3C78_F1E3_C78F_1E1E
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [63:0] s_data,
    input  logic [1:0]  s_hdr,
    input  logic        lpi_req,
    output logic [63:0] scr_data,
    output logic        scr_enable,
    output logic        scr_rst,
    input  logic [63:0] scr_dout,
    output logic        m_valid,
    output logic [63:0] m_data,
    output logic [1:0]  m_hdr,
    output logic        hdr_err,
    output logic [1:0]  state,
    output logic [15:0] err_count
);

    localparam int unsigned CNT_MAX = (SEED_CYCLES > WAKE_CYCLES) ? SEED_CYCLES : WAKE_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        ST_SEED   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_LPI    = 2'b10,
        ST_WAKE   = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             m_valid_q, m_valid_d;
    logic [1:0]       m_hdr_q, m_hdr_d;
    logic             hdr_err_q, hdr_err_d;

    // State register and shared seed/wake down-counter
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= ST_SEED;
            cnt_q   <= CNT_W'(SEED_CYCLES - 1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the wake counter is reloaded on every LPI exit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_SEED: begin
                if (cnt_q == '0) state_d = ST_ACTIVE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_ACTIVE: begin
                if (lpi_req) state_d = ST_LPI;
            end
            ST_LPI: begin
                if (!lpi_req) begin
                    state_d = ST_WAKE;
                    cnt_d   = CNT_W'(WAKE_CYCLES - 1);
                end
            end
            ST_WAKE: begin
                if (lpi_req)           state_d = ST_LPI;
                else if (cnt_q == '0)  state_d = ST_ACTIVE;
                else                   cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_SEED;
        endcase
    end

    // Output logic: block source mux, scrambler control and header for next cycle
    always_comb begin
        s_ready    = 1'b0;
        scr_enable = 1'b0;
        scr_rst    = 1'b0;
        scr_data   = '0;
        m_valid_d  = 1'b0;
        m_hdr_d    = 2'b00;
        hdr_err_d  = 1'b0;
        case (state_q)
            ST_SEED: begin
                scr_rst = 1'b1;
            end
            ST_ACTIVE: begin
                s_ready    = 1'b1;
                scr_enable = 1'b1;
                m_valid_d  = 1'b1;
                if (s_valid) begin
                    if (s_hdr == 2'b01 || s_hdr == 2'b10) begin
                        scr_data = s_data;
                        m_hdr_d  = s_hdr;
                    end else begin
                        scr_data  = ERR_BLOCK;
                        m_hdr_d   = 2'b10;
                        hdr_err_d = 1'b1;
                    end
                end else begin
                    scr_data = IDLE_BLOCK;
                    m_hdr_d  = 2'b10;
                end
            end
            ST_LPI: begin
                m_valid_d = 1'b1;
                scr_data  = LPI_BLOCK;
                m_hdr_d   = 2'b10;
            end
            ST_WAKE: begin
                scr_enable = 1'b1;
                m_valid_d  = 1'b1;
                scr_data   = IDLE_BLOCK;
                m_hdr_d    = 2'b10;
            end
            default: begin
                scr_rst = 1'b1;
            end
        endcase
    end

    // Header path registered to line up with the scrambler's one-cycle latency
    always_ff @(posedge CLK) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_hdr_q   <= 2'b00;
            hdr_err_q <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_hdr_q   <= m_hdr_d;
            hdr_err_q <= hdr_err_d;
        end
    end

`ifdef TX_SCRAM_ERRCNT_EN
    logic [15:0] err_cnt_q;

    // Saturating illegal-header counter, updates alongside hdr_err
    always_ff @(posedge CLK) begin
        if (rst) begin
            err_cnt_q <= 16'h0000;
        end else if (hdr_err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 16'h0000;
`endif

    assign m_valid = m_valid_q;
    assign m_hdr   = m_hdr_q;
    assign hdr_err = hdr_err_q;
    assign m_data  = scr_dout;
    assign state   = state_q;

endmodule

// File: tb/tb_tx_scram_seq.sv
// Directed bench for tx_scram_seq with a behavioural 58-bit self-synchronous
// scrambler (x^58 + x^39 + 1, LSB first) wired to the scr_* ports.
module tb_tx_scram_seq;

    localparam logic [63:0] IDLE_BLK = 64'h0000_0000_0000_001E;
    localparam logic [63:0] LPI_BLK  = 64'h0C18_3060_C183_061E;
    localparam logic [63:0] ERR_BLK  = 64'h3C78_F1E3_C78F_1E1E;
    localparam logic [1:0]  SEED = 2'b00, ACT = 2'b01, LPI = 2'b10, WAKE = 2'b11;

    logic        CLK;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic [1:0]  s_hdr;
    logic        lpi_req;
    logic [63:0] scr_data;
    logic        scr_enable;
    logic        scr_rst;
    logic [63:0] scr_dout;
    logic        m_valid;
    logic [63:0] m_data;
    logic [1:0]  m_hdr;
    logic        hdr_err;
    logic [1:0]  state;
    logic [15:0] err_count;

    int unsigned n_total;
    int unsigned n_pass;
    int unsigned n_fail;
    logic [57:0] ref_st;
    logic [57:0] scr_st;
    logic [15:0] exp_cnt;

    tx_scram_seq dut (
        .CLK        (CLK),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_hdr      (s_hdr),
        .lpi_req    (lpi_req),
        .scr_data   (scr_data),
        .scr_enable (scr_enable),
        .scr_rst    (scr_rst),
        .scr_dout   (scr_dout),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_hdr      (m_hdr),
        .hdr_err    (hdr_err),
        .state      (state),
        .err_count  (err_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Scramble one block; st[0] holds the most recent scrambled bit
    function automatic logic [121:0] scram(input logic [57:0] st_in, input logic [63:0] d);
        logic [57:0] st;
        logic [63:0] o;
        st = st_in;
        for (int i = 0; i < 64; i++) begin
            o[i] = d[i] ^ st[38] ^ st[57];
            st   = {st[56:0], o[i]};
        end
        return {st, o};
    endfunction

    // Scrambler with one cycle of latency; pass-through when disabled
    always_ff @(posedge CLK) begin
        if (scr_rst) begin
            scr_st   <= '1;
            scr_dout <= '0;
        end else if (scr_enable) begin
            {scr_st, scr_dout} <= scram(scr_st, scr_data);
        end else begin
            scr_dout <= scr_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One sequencer cycle: check the combinational side, clock, check the registered side
    task automatic cycle(input string tag, input logic [1:0] e_state, input logic e_rdy,
                         input logic [63:0] e_blk, input logic e_en,
                         input logic [1:0] e_hdr, input logic e_herr);
        logic [63:0] e_m;
        #1;
        chk({tag, " state"},      64'(state),      64'(e_state));
        chk({tag, " s_ready"},    64'(s_ready),    64'(e_rdy));
        chk({tag, " scr_data"},   scr_data,        e_blk);
        chk({tag, " scr_enable"}, 64'(scr_enable), 64'(e_en));
        chk({tag, " scr_rst"},    64'(scr_rst),    64'(1'b0));
        if (e_en) {ref_st, e_m} = scram(ref_st, e_blk);
        else      e_m = e_blk;
        @(posedge CLK); #1;
        chk({tag, " m_valid"}, 64'(m_valid), 64'(1'b1));
        chk({tag, " m_hdr"},   64'(m_hdr),   64'(e_hdr));
        chk({tag, " hdr_err"}, 64'(hdr_err), 64'(e_herr));
        chk({tag, " m_data"},  m_data,       e_m);
    endtask

    // Four SEED cycles after a reset edge, then ACTIVE with m_valid still low
    task automatic seed_phase(input string tag);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk({tag, " seed scr_rst"},    64'(scr_rst),    64'(1'b1));
            chk({tag, " seed state"},      64'(state),      64'(SEED));
            chk({tag, " seed s_ready"},    64'(s_ready),    64'(1'b0));
            chk({tag, " seed m_valid"},    64'(m_valid),    64'(1'b0));
            chk({tag, " seed scr_enable"}, 64'(scr_enable), 64'(1'b0));
            @(posedge CLK); #1;
        end
        chk({tag, " post-seed m_valid"}, 64'(m_valid), 64'(1'b0));
        chk({tag, " post-seed scr_rst"}, 64'(scr_rst), 64'(1'b0));
        ref_st = '1;
    endtask

    initial begin
        n_total = 0; n_pass = 0; n_fail = 0;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_hdr = 2'b00; lpi_req = 1'b0;
        ref_st = '1;
        exp_cnt = 16'h0000;

        // Reset values
        repeat (3) @(posedge CLK);
        #1;
        chk("rst s_ready",    64'(s_ready),    64'(1'b0));
        chk("rst m_valid",    64'(m_valid),    64'(1'b0));
        chk("rst m_hdr",      64'(m_hdr),      64'(2'b00));
        chk("rst hdr_err",    64'(hdr_err),    64'(1'b0));
        chk("rst state",      64'(state),      64'(SEED));
        chk("rst err_count",  64'(err_count),  64'(16'h0000));
        chk("rst scr_rst",    64'(scr_rst),    64'(1'b1));
        chk("rst scr_enable", 64'(scr_enable), 64'(1'b0));
        chk("rst scr_data",   scr_data,        64'h0);
        rst = 1'b0;
        seed_phase("boot");
        cycle("first idle", ACT, 1'b1, IDLE_BLK, 1'b1, 2'b10, 1'b0);

        // Data stream
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_hdr = 2'b01;
            s_data  = 64'h0123_4567_89AB_CDEF + 64'(i) * 64'h1111_1111_1111_1111;
            cycle($sformatf("data%0d", i), ACT, 1'b1, s_data, 1'b1, 2'b01, 1'b0);
        end
        s_hdr = 2'b10; s_data = 64'hFEDC_BA98_7654_3210;
        cycle("ctrl beat", ACT, 1'b1, s_data, 1'b1, 2'b10, 1'b0);

        // Gaps: valid 1,0,1
        s_hdr = 2'b01; s_data = 64'hDEAD_BEEF_0000_0001;
        cycle("gap pre", ACT, 1'b1, s_data, 1'b1, 2'b01, 1'b0);
        s_valid = 1'b0;
        cycle("gap idle", ACT, 1'b1, IDLE_BLK, 1'b1, 2'b10, 1'b0);
        s_valid = 1'b1; s_data = 64'hDEAD_BEEF_0000_0002;
        cycle("gap post", ACT, 1'b1, s_data, 1'b1, 2'b01, 1'b0);

        // Illegal headers 11 and 00
        s_hdr = 2'b11; s_data = 64'h5555_5555_5555_5555;
        cycle("bad hdr 11", ACT, 1'b1, ERR_BLK, 1'b1, 2'b10, 1'b1);
`ifdef TX_SCRAM_ERRCNT_EN
        exp_cnt = 16'd1;
`endif
        chk("err_count after 11", 64'(err_count), 64'(exp_cnt));
        s_hdr = 2'b00;
        cycle("bad hdr 00", ACT, 1'b1, ERR_BLK, 1'b1, 2'b10, 1'b1);
`ifdef TX_SCRAM_ERRCNT_EN
        exp_cnt = 16'd2;
`endif
        chk("err_count after 00", 64'(err_count), 64'(exp_cnt));
        s_hdr = 2'b01; s_data = 64'h0F0F_0F0F_F0F0_F0F0;
        cycle("good after bad", ACT, 1'b1, s_data, 1'b1, 2'b01, 1'b0);

        // EEE: beat accepted alongside lpi_req, then LPI, then timed wake
        s_data = 64'h1234_5678_9ABC_DEF0; lpi_req = 1'b1;
        cycle("lpi entry beat", ACT, 1'b1, s_data, 1'b1, 2'b01, 1'b0);
        for (int i = 0; i < 9; i++)
            cycle($sformatf("lpi%0d", i), LPI, 1'b0, LPI_BLK, 1'b0, 2'b10, 1'b0);
        lpi_req = 1'b0;
        cycle("lpi exit", LPI, 1'b0, LPI_BLK, 1'b0, 2'b10, 1'b0);
        for (int i = 0; i < 16; i++)
            cycle($sformatf("wake%0d", i), WAKE, 1'b0, IDLE_BLK, 1'b1, 2'b10, 1'b0);
        cycle("after wake", ACT, 1'b1, s_data, 1'b1, 2'b01, 1'b0);

        // Re-assert lpi_req on wake cycle 5
        s_valid = 1'b0; lpi_req = 1'b1;
        cycle("lpi2 entry", ACT, 1'b1, IDLE_BLK, 1'b1, 2'b10, 1'b0);
        lpi_req = 1'b0;
        cycle("lpi2", LPI, 1'b0, LPI_BLK, 1'b0, 2'b10, 1'b0);
        for (int i = 1; i <= 4; i++)
            cycle($sformatf("wake2_%0d", i), WAKE, 1'b0, IDLE_BLK, 1'b1, 2'b10, 1'b0);
        lpi_req = 1'b1;
        cycle("wake2_5 req", WAKE, 1'b0, IDLE_BLK, 1'b1, 2'b10, 1'b0);
        cycle("relpi", LPI, 1'b0, LPI_BLK, 1'b0, 2'b10, 1'b0);
        lpi_req = 1'b0;
        cycle("relpi exit", LPI, 1'b0, LPI_BLK, 1'b0, 2'b10, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle($sformatf("wake3_%0d", i), WAKE, 1'b0, IDLE_BLK, 1'b1, 2'b10, 1'b0);

        // One-cycle reset in the middle of WAKE
        rst = 1'b1;
        #1;
        chk("pre-rst state", 64'(state), 64'(WAKE));
        @(posedge CLK); #1;
        rst = 1'b0;
        chk("midrst state",     64'(state),     64'(SEED));
        chk("midrst scr_rst",   64'(scr_rst),   64'(1'b1));
        chk("midrst m_valid",   64'(m_valid),   64'(1'b0));
        chk("midrst m_hdr",     64'(m_hdr),     64'(2'b00));
        chk("midrst scr_data",  scr_data,       64'h0);
        chk("midrst err_count", 64'(err_count), 64'(16'h0000));
        seed_phase("reseed");
        cycle("reseed idle", ACT, 1'b1, IDLE_BLK, 1'b1, 2'b10, 1'b0);
        s_valid = 1'b1; s_hdr = 2'b10; s_data = 64'hCAFE_F00D_0000_0078;
        cycle("reseed data", ACT, 1'b1, s_data, 1'b1, 2'b10, 1'b0);

`ifdef TX_SCRAM_ERRCNT_EN
        // Counter saturation
        s_hdr = 2'b11;
        repeat (70000) @(posedge CLK);
        #1;
        chk("err_count saturate", 64'(err_count), 64'(16'hFFFF));
        chk("hdr_err held", 64'(hdr_err), 64'(1'b1));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tx_scram_seq.md
# tx_scram_seq

Transmit-side sequencer for the 64-bit parallel 58-bit-LFSR scrambler in the 64b/66b PCS. It seeds the scrambler after reset and feeds it one 64-bit block every cycle. Gaps in the MAC stream are filled with idle control blocks, and malformed headers are replaced with error blocks. The sync header is delayed to stay aligned with the scrambler's one-cycle latency. It also runs the EEE low-power sequence: scrambler bypass during LPI, then a timed wake.

## Interface
- SEED_CYCLES, 4: cycles scr_rst is held after reset (min 1).
- WAKE_CYCLES, 16: idle blocks sent after LPI exit before data is accepted (min 1).
- IDLE_BLOCK, 64'h0000_0000_0000_001E: fill block, type 0x1E, all /I/.
- LPI_BLOCK, 64'h0C18_3060_C183_061E: type 0x1E, eight /LI/ (7'h06).
- ERR_BLOCK, 64'h3C78_F1E3_C78F_1E1E: type 0x1E, eight /E/ (7'h1E).
- CLK  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  MAC block valid.
- s_ready  out  1  sequencer accepts block this cycle.
- s_data  in  64  MAC block payload, LSB first on line.
- s_hdr  in  2  sync header (2'b01 data, 2'b10 control).
- lpi_req  in  1  level request for low-power idle.
- scr_data  out  64  block to scrambler data_in.
- scr_enable  out  1  scrambler enable (0 = pass-through).
- scr_rst  out  1  scrambler LFSR reset.
- scr_dout  in  64  scrambler data_out.
- m_valid  out  1  output block valid.
- m_data  out  64  scrambled block (= scr_dout).
- m_hdr  out  2  sync header aligned to m_data.
- hdr_err  out  1  one-cycle pulse, aligned with the substituted block on m_data.
- state  out  2  00 SEED, 01 ACTIVE, 10 LPI, 11 WAKE.
- err_count  out  16  illegal-header counter (see Configuration).

## Operation
- Block source each cycle: accepted s_data, IDLE_BLOCK, LPI_BLOCK or ERR_BLOCK.
  - scr_data is a combinational mux of these sources.
  - The header is registered into m_hdr; m_data = scr_dout passes straight through.
- SEED (reset state):
  - scr_rst=1, scr_enable=0, s_ready=0, m_valid=0.
  - A down-counter loaded with SEED_CYCLES-1 counts to 0, then the state moves to ACTIVE.
- ACTIVE:
  - scr_enable=1; s_ready=1 combinationally.
  - s_valid=1: forward s_data and s_hdr.
  - s_hdr illegal (00/11): send ERR_BLOCK with header 10, pulse hdr_err.
  - s_valid=0: send IDLE_BLOCK with header 10.
  - lpi_req=1 sampled: the current cycle completes normally; LPI from next cycle.
- LPI:
  - scr_enable=0, s_ready=0.
  - Sends LPI_BLOCK with header 10 every cycle; m_valid stays 1.
  - lpi_req=0: go to WAKE and load the wake counter with WAKE_CYCLES-1.
- WAKE:
  - scr_enable=1, s_ready=0, sends IDLE_BLOCK.
  - lpi_req=1: return to LPI next cycle; the counter is discarded.
  - Counter reaches 0: go to ACTIVE.
- Reset mid-operation: any state returns to SEED next cycle; in-flight block dropped.
- The LFSR is never re-seeded on the LPI-to-WAKE transition.

## Timing
- Reset values:
  - s_ready=0, m_valid=0, m_hdr=2'b00, hdr_err=0, state=00, err_count=0.
  - scr_rst=1, scr_enable=0, scr_data=0.
- Latency: block on scr_data in cycle N appears on m_data/m_hdr in cycle N+1; m_valid=1 in N+1.
- m_valid first rises SEED_CYCLES+1 cycles after rst falls. It then stays 1 every cycle until the next reset (continuous line).
- Handshake: transfer occurs when s_valid && s_ready. Data is not held back; s_ready does not depend on s_valid.
- lpi_req asserted in the same cycle as a valid beat: the beat is accepted, and LPI begins the next cycle.
- State transitions are registered; the state output reflects the current registered state.

## Configuration
- TX_SCRAM_ERRCNT_EN defined: err_count increments on every illegal-header accepted beat.
  - Updates in the same cycle as hdr_err.
  - Saturates at 16'hFFFF; cleared only by rst.
- Undefined: counter logic is omitted and err_count is tied to 16'h0000; hdr_err is unaffected.

## Test plan
- Reset: rst high 3 cycles then low → scr_rst=1 for 4 cycles, then 0; m_valid rises on cycle 5; first m_hdr=10 and scrambled IDLE_BLOCK.
- Data stream: 8 beats with s_hdr=01 after seeding → m_hdr=01 one cycle after each accept. m_data must match a reference LFSR seeded all-ones below its bit 6 and otherwise all ones.
- Gaps: s_valid toggling 1,0,1 → the middle output block is scrambled IDLE_BLOCK with hdr 10; m_valid never drops.
- Bad header: s_hdr=11 once → m_hdr=10, pre-scramble block ERR_BLOCK, hdr_err pulse 1 cycle. With the macro defined, err_count=1; 70000 bad beats → 16'hFFFF.
- EEE: lpi_req high 10 cycles → scr_enable=0, m_data=LPI_BLOCK unscrambled. Release → 16 scrambled IDLE_BLOCKs with s_ready=0, then s_ready=1. Re-assert lpi_req at wake cycle 5 → LPI the next cycle.
- Reset mid-WAKE: rst for 1 cycle → state=00, scr_rst=1, m_valid=0 the next cycle; full 4-cycle seed repeats.
